// File: rtl/ball_collision_check.sv
// Collision stage between the ball position generator and the display: looks each
// proposed position up in the maze ROM and commits only legal moves, sliding per axis.
module ball_collision_check #(
  parameter int unsigned COL_BITS    = 7,
  parameter int unsigned ROW_BITS    = 7,
  parameter int unsigned ROM_LATENCY = 1,
  parameter logic [7:0]  START_X     = 8'd1,
  parameter logic [7:0]  START_Y     = 8'd1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pos_valid,
  output logic                         pos_ready,
  input  logic [7:0]                   x_in,
  input  logic [7:0]                   y_in,
  input  logic                         game_restart,
  output logic [ROW_BITS+COL_BITS-1:0] map_addr,
  input  logic [1:0]                   map_data,
  output logic [7:0]                   ball_x,
  output logic [7:0]                   ball_y,
  output logic                         ball_valid,
  output logic                         wall_hit,
  output logic                         hole_fall,
  output logic                         goal_reached
);
  localparam int unsigned AW = ROW_BITS + COL_BITS;

  typedef enum logic [1:0] {IDLE, LOOKUP, GOAL} state_t;
  typedef enum logic [1:0] {DIAG, XONLY, YONLY} try_t;
  typedef enum logic [1:0] {FLOOR = 2'b00, WALL = 2'b01, HOLE = 2'b10, GOAL_CELL = 2'b11} cell_t;

  state_t        state_q, state_d;
  try_t          try_q, try_d, next_try;
  logic [7:0]    px_q, px_d, py_q, py_d;
  logic [7:0]    bx_q, bx_d, by_q, by_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          valid_q, valid_d, wall_q, wall_d, hole_q, hole_d, goal_q, goal_d;

  logic          has_next, blocked;
  logic [7:0]    cur_x, cur_y, nxt_x, nxt_y;
  logic          cur_ok, nxt_ok, in_ok;
  logic [AW-1:0] nxt_addr, in_addr;

  // Cells beyond the map edge behave as walls and never touch the ROM.
  function automatic logic in_range(input logic [7:0] x, input logic [7:0] y);
    return ({24'd0, x} < (32'd1 << COL_BITS)) && ({24'd0, y} < (32'd1 << ROW_BITS));
  endfunction

  // Candidate cell of the current try and of the try that follows it.
  always_comb begin
    cur_x    = (try_q == YONLY) ? bx_q : px_q;
    cur_y    = (try_q == XONLY) ? by_q : py_q;
    has_next = 1'b0;
    next_try = YONLY;
    case (try_q)
      DIAG: begin
        if (px_q != bx_q) begin
          has_next = 1'b1;
          next_try = XONLY;
        end else if (py_q != by_q) begin
          has_next = 1'b1;
        end
      end
      XONLY:   has_next = (py_q != by_q);
      default: has_next = 1'b0;
    endcase
    nxt_x = (next_try == YONLY) ? bx_q : px_q;
    nxt_y = (next_try == XONLY) ? by_q : py_q;
  end

  assign cur_ok   = in_range(cur_x, cur_y);
  assign nxt_ok   = in_range(nxt_x, nxt_y);
  assign in_ok    = in_range(x_in, y_in);
  assign nxt_addr = {nxt_y[ROW_BITS-1:0], nxt_x[COL_BITS-1:0]};
  assign in_addr  = {y_in[ROW_BITS-1:0], x_in[COL_BITS-1:0]};

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    try_d   = try_q;
    px_d    = px_q;
    py_d    = py_q;
    bx_d    = bx_q;
    by_d    = by_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    wall_d  = 1'b0;
    hole_d  = 1'b0;
    goal_d  = goal_q;
    blocked = 1'b0;

    case (state_q)
      IDLE: begin
        if (pos_valid) begin
          px_d = x_in;
          py_d = y_in;
          if ((x_in != bx_q) || (y_in != by_q)) begin
            state_d = LOOKUP;
            try_d   = DIAG;
            cnt_d   = 2'd0;
            if (in_ok) addr_d = in_addr;
          end
        end
      end

      LOOKUP: begin
        if (!cur_ok) begin
          blocked = 1'b1;
        end else if (cnt_q == 2'(ROM_LATENCY)) begin
          case (cell_t'(map_data))
            FLOOR: begin
              bx_d    = cur_x;
              by_d    = cur_y;
              valid_d = 1'b1;
              wall_d  = (try_q != DIAG);
              state_d = IDLE;
            end
            GOAL_CELL: begin
              bx_d    = cur_x;
              by_d    = cur_y;
              valid_d = 1'b1;
              wall_d  = (try_q != DIAG);
              goal_d  = 1'b1;
              state_d = GOAL;
            end
            HOLE: begin
              bx_d    = START_X;
              by_d    = START_Y;
              valid_d = 1'b1;
              hole_d  = 1'b1;
              wall_d  = (try_q != DIAG);
              state_d = IDLE;
            end
            default: blocked = 1'b1;
          endcase
        end else begin
          cnt_d = cnt_q + 2'd1;
        end

        if (blocked) begin
          if (has_next) begin
            try_d = next_try;
            cnt_d = 2'd0;
            if (nxt_ok) addr_d = nxt_addr;
          end else begin
            wall_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      GOAL:    state_d = GOAL;
      default: state_d = IDLE;
    endcase

    // Restart outranks any lookup in flight and never emits pulses.
    if (game_restart) begin
      state_d = IDLE;
      bx_d    = START_X;
      by_d    = START_Y;
      goal_d  = 1'b0;
      valid_d = 1'b0;
      wall_d  = 1'b0;
      hole_d  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      try_q   <= DIAG;
      px_q    <= 8'd0;
      py_q    <= 8'd0;
      bx_q    <= START_X;
      by_q    <= START_Y;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      wall_q  <= 1'b0;
      hole_q  <= 1'b0;
      goal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      try_q   <= try_d;
      px_q    <= px_d;
      py_q    <= py_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      wall_q  <= wall_d;
      hole_q  <= hole_d;
      goal_q  <= goal_d;
    end
  end

  assign pos_ready    = (state_q == IDLE);
  assign map_addr     = addr_q;
  assign ball_x       = bx_q;
  assign ball_y       = by_q;
  assign ball_valid   = valid_q;
  assign wall_hit     = wall_q;
  assign hole_fall    = hole_q;
  assign goal_reached = goal_q;
endmodule

// File: tb/tb_ball_collision_check.sv
// Bench for ball_collision_check: directed vector table, abort sequences, then random
// moves over a random maze checked against a candidate-list reference model.
module tb_ball_collision_check;
  localparam int L  = 1;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pos_valid = 1'b0;
  logic          pos_ready;
  logic [7:0]    x_in = 8'd0, y_in = 8'd0;
  logic          game_restart = 1'b0;
  logic [AW-1:0] map_addr;
  logic [1:0]    map_data;
  logic [7:0]    ball_x, ball_y;
  logic          ball_valid, wall_hit, hole_fall, goal_reached;

  int n_checks = 0;
  int n_fail   = 0;

  ball_collision_check #(
    .COL_BITS(7), .ROW_BITS(7), .ROM_LATENCY(L), .START_X(8'd1), .START_Y(8'd1)
  ) dut (
    .clk(clk), .reset(reset), .pos_valid(pos_valid), .pos_ready(pos_ready),
    .x_in(x_in), .y_in(y_in), .game_restart(game_restart), .map_addr(map_addr),
    .map_data(map_data), .ball_x(ball_x), .ball_y(ball_y), .ball_valid(ball_valid),
    .wall_hit(wall_hit), .hole_fall(hole_fall), .goal_reached(goal_reached)
  );

  always #5 clk = ~clk;

  // Synchronous maze ROM with L cycles of latency.
  logic [1:0] map_mem [0:16383];
  logic [1:0] rom_pipe [0:2];
  always @(posedge clk) begin
    rom_pipe[0] <= map_mem[map_addr];
    for (int i = 1; i < 3; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign map_data = rom_pipe[L-1];

  typedef struct {
    logic [7:0] bx, by;
    logic       valid, wall, hole, goal, none;
    int         lat;
  } out_t;

  typedef struct {
    logic [7:0]    px, py;
    out_t          e;
    logic          chk_addr;
    logic [AW-1:0] a01;
  } vec_t;

  function automatic int cell_idx(input logic [7:0] x, input logic [7:0] y);
    return int'(y) * 128 + int'(x);
  endfunction

  function automatic vec_t mk(input logic [7:0] px, py, bx, by,
                              input logic v, w, h, g, n, input int lat,
                              input logic ca, input logic [AW-1:0] a);
    vec_t t;
    t.px = px; t.py = py;
    t.e.bx = bx; t.e.by = by; t.e.valid = v; t.e.wall = w; t.e.hole = h;
    t.e.goal = g; t.e.none = n; t.e.lat = lat;
    t.chk_addr = ca; t.a01 = a;
    return t;
  endfunction

  // Reference: walk the candidate list DIAG, XONLY, YONLY and pick the first non-wall.
  function automatic out_t model(input logic [7:0] bx, by, px, py);
    out_t e;
    logic [7:0] cx [$];
    logic [7:0] cy [$];
    e.bx = bx; e.by = by; e.valid = 0; e.wall = 0; e.hole = 0; e.goal = 0; e.none = 0; e.lat = 0;
    if (px == bx && py == by) begin
      e.none = 1;
      return e;
    end
    cx.push_back(px); cy.push_back(py);
    if (px != bx) begin cx.push_back(px); cy.push_back(by); end
    if (py != by) begin cx.push_back(bx); cy.push_back(py); end
    for (int i = 0; i < cx.size(); i++) begin
      logic [7:0] x, y;
      logic [1:0] c;
      x = cx[i]; y = cy[i];
      if (x >= 8'd128 || y >= 8'd128) begin
        e.lat += 1;
        continue;
      end
      e.lat += L + 1;
      c = map_mem[cell_idx(x, y)];
      if (c != 2'b01) begin
        e.valid = 1;
        e.wall  = (i > 0);
        if (c == 2'b10) begin
          e.bx = 8'd1; e.by = 8'd1; e.hole = 1;
        end else begin
          e.bx = x; e.by = y; e.goal = (c == 2'b11);
        end
        return e;
      end
    end
    e.wall = 1;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one proposal, then check the outcome and its exact latency.
  task automatic do_move(input string tag, input logic [7:0] px, py, input out_t e,
                         input logic chk_addr, input logic [AW-1:0] a01);
    int cyc;
    logic seen;
    x_in = px; y_in = py; pos_valid = 1'b1;
    tick();
    pos_valid = 1'b0;
    if (e.none) begin
      seen = 0;
      repeat (6) begin
        seen |= ball_valid | wall_hit | hole_fall;
        tick();
      end
      check({tag, " same_pos_pulse"}, int'(seen), 0);
      check({tag, " same_pos_ready"}, int'(pos_ready), 1);
      check({tag, " same_pos_ball"}, int'({ball_x, ball_y}), int'({e.bx, e.by}));
      return;
    end
    cyc = 0;
    while (!(ball_valid | wall_hit | hole_fall) && cyc < 40) begin
      if (chk_addr && cyc < 2) check({tag, " map_addr"}, int'(map_addr), int'(a01));
      tick();
      cyc++;
    end
    check({tag, " latency"}, cyc, e.lat);
    check({tag, " ball_x"}, int'(ball_x), int'(e.bx));
    check({tag, " ball_y"}, int'(ball_y), int'(e.by));
    check({tag, " ball_valid"}, int'(ball_valid), int'(e.valid));
    check({tag, " wall_hit"}, int'(wall_hit), int'(e.wall));
    check({tag, " hole_fall"}, int'(hole_fall), int'(e.hole));
    check({tag, " goal_reached"}, int'(goal_reached), int'(e.goal));
    check({tag, " pos_ready"}, int'(pos_ready), int'(!e.goal));
    tick();
    check({tag, " pulse_width"}, int'({ball_valid, wall_hit, hole_fall}), 0);
  endtask

  task automatic pulse_restart();
    game_restart = 1'b1;
    tick();
    game_restart = 1'b0;
  endtask

  task automatic expect_quiet(input string tag, input int n);
    logic seen;
    seen = 0;
    repeat (n) begin
      seen |= ball_valid | wall_hit | hole_fall;
      tick();
    end
    check({tag, " no_pulse"}, int'(seen), 0);
  endtask

  vec_t tbl [11];
  out_t e;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bx, by, px, py;

    for (int i = 0; i < 16384; i++) map_mem[i] = 2'b00;
    map_mem[cell_idx(3, 3)]   = 2'b01;
    map_mem[cell_idx(4, 3)]   = 2'b01;
    map_mem[cell_idx(4, 2)]   = 2'b01;
    map_mem[cell_idx(1, 4)]   = 2'b01;
    map_mem[cell_idx(10, 10)] = 2'b10;
    map_mem[cell_idx(7, 7)]   = 2'b11;

    //          px      py      bx     by    v  w  h  g  n  lat addr? addr
    tbl[0]  = mk(8'd2,   8'd1,   8'd2, 8'd1, 1, 0, 0, 0, 0, 2, 1, 14'd130);
    tbl[1]  = mk(8'd2,   8'd2,   8'd2, 8'd2, 1, 0, 0, 0, 0, 2, 0, '0);
    tbl[2]  = mk(8'd3,   8'd3,   8'd3, 8'd2, 1, 1, 0, 0, 0, 4, 0, '0);
    tbl[3]  = mk(8'd4,   8'd3,   8'd3, 8'd2, 0, 1, 0, 0, 0, 6, 0, '0);
    tbl[4]  = mk(8'd2,   8'd2,   8'd2, 8'd2, 1, 0, 0, 0, 0, 2, 0, '0);
    tbl[5]  = mk(8'd10,  8'd10,  8'd1, 8'd1, 1, 0, 1, 0, 0, 2, 0, '0);
    tbl[6]  = mk(8'd200, 8'd2,   8'd1, 8'd2, 1, 1, 0, 0, 0, 4, 1, 14'd1290);
    tbl[7]  = mk(8'd200, 8'd200, 8'd1, 8'd2, 0, 1, 0, 0, 0, 3, 0, '0);
    tbl[8]  = mk(8'd1,   8'd2,   8'd1, 8'd2, 0, 0, 0, 0, 1, 0, 0, '0);
    tbl[9]  = mk(8'd1,   8'd4,   8'd1, 8'd2, 0, 1, 0, 0, 0, 4, 0, '0);
    tbl[10] = mk(8'd7,   8'd7,   8'd7, 8'd7, 1, 0, 0, 1, 0, 2, 0, '0);

    // Reset state, held and after release.
    repeat (3) tick();
    check("rst_ball", int'({ball_x, ball_y}), int'({8'd1, 8'd1}));
    check("rst_map_addr", int'(map_addr), 0);
    @(negedge clk) reset = 1'b1;
    tick();
    check("rel_ball", int'({ball_x, ball_y}), int'({8'd1, 8'd1}));
    check("rel_ready", int'(pos_ready), 1);
    check("rel_flags", int'({ball_valid, wall_hit, hole_fall, goal_reached}), 0);
    check("rel_map_addr", int'(map_addr), 0);

    for (int i = 0; i < 11; i++)
      do_move($sformatf("vec%0d", i), tbl[i].px, tbl[i].py, tbl[i].e, tbl[i].chk_addr, tbl[i].a01);

    // In GOAL, proposals are ignored until restart.
    x_in = 8'd2; y_in = 8'd2; pos_valid = 1'b1;
    expect_quiet("goal_ignore", 5);
    pos_valid = 1'b0;
    check("goal_ball", int'({ball_x, ball_y}), int'({8'd7, 8'd7}));
    check("goal_ready", int'(pos_ready), 0);
    check("goal_sticky", int'(goal_reached), 1);
    pulse_restart();
    check("restart_ball", int'({ball_x, ball_y}), int'({8'd1, 8'd1}));
    check("restart_goal", int'(goal_reached), 0);
    check("restart_ready", int'(pos_ready), 1);
    expect_quiet("restart", 3);

    // Restart in the middle of a lookup.
    do_move("pre_rs", 8'd2, 8'd1, tbl[0].e, 1'b0, '0);
    x_in = 8'd2; y_in = 8'd2; pos_valid = 1'b1;
    tick();
    pos_valid = 1'b0;
    pulse_restart();
    check("rs_abort_ball", int'({ball_x, ball_y}), int'({8'd1, 8'd1}));
    check("rs_abort_ready", int'(pos_ready), 1);
    expect_quiet("rs_abort", 5);
    check("rs_abort_ball2", int'({ball_x, ball_y}), int'({8'd1, 8'd1}));

    // Asynchronous reset in the middle of a lookup.
    do_move("pre_rst", 8'd2, 8'd1, tbl[0].e, 1'b0, '0);
    x_in = 8'd3; y_in = 8'd1; pos_valid = 1'b1;
    tick();
    pos_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_abort_ball", int'({ball_x, ball_y}), int'({8'd1, 8'd1}));
    check("rst_abort_addr", int'(map_addr), 0);
    check("rst_abort_ready", int'(pos_ready), 1);
    check("rst_abort_flags", int'({ball_valid, wall_hit, hole_fall, goal_reached}), 0);
    @(negedge clk) reset = 1'b1;
    tick();
    expect_quiet("rst_abort", 5);
    check("rst_abort_ball2", int'({ball_x, ball_y}), int'({8'd1, 8'd1}));

    // Random maze, random local moves plus out-of-range and repeated proposals.
    for (int i = 0; i < 16384; i++) begin
      int r;
      r = $urandom_range(0, 99);
      map_mem[i] = (r < 78) ? 2'b00 : (r < 93) ? 2'b01 : (r < 97) ? 2'b10 : 2'b11;
    end
    map_mem[cell_idx(1, 1)] = 2'b00;
    bx = 8'd1; by = 8'd1;
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        px = bx; py = by;
      end else if (r == 1) begin
        px = 8'($urandom_range(120, 255));
        py = 8'(by + 8'($urandom_range(0, 2)) - 8'd1);
      end else begin
        px = 8'(bx + 8'($urandom_range(0, 2)) - 8'd1);
        py = 8'(by + 8'($urandom_range(0, 2)) - 8'd1);
      end
      e = model(bx, by, px, py);
      do_move($sformatf("rnd%0d", n), px, py, e, 1'b0, '0);
      bx = e.bx; by = e.by;
      if (e.goal) begin
        pulse_restart();
        check("rnd_restart_ball", int'({ball_x, ball_y}), int'({8'd1, 8'd1}));
        check("rnd_restart_goal", int'(goal_reached), 0);
        bx = 8'd1; by = 8'd1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
